riscv_muldiv_unit: RTL and testbench

//  Multi-cycle RV32M execute unit. Decodes funct3 and funct7 from the raw instruction and computes
//  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Sits beside the single-cycle ALU in the execute stage.

---
 rtl/riscv_muldiv_pkg.sv | 25 ++
 rtl/riscv_divider_iter.sv | 62 ++++++
 rtl/riscv_muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_muldiv_pkg.sv
// RV32M encodings and FSM state type shared by the mul/div unit and its bench.
// No logic here beyond constants and types.
package riscv_muldiv_pkg;

  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] FNC7_MULDIV   = 7'b0000001;

  localparam logic [2:0] FNC_MUL    = 3'b000;
  localparam logic [2:0] FNC_MULH   = 3'b001;
  localparam logic [2:0] FNC_MULHSU = 3'b010;
  localparam logic [2:0] FNC_MULHU  = 3'b011;
  localparam logic [2:0] FNC_DIV    = 3'b100;
  localparam logic [2:0] FNC_DIVU   = 3'b101;
  localparam logic [2:0] FNC_REM    = 3'b110;
  localparam logic [2:0] FNC_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_t;

endpackage

// File: rtl/riscv_divider_iter.sv
// Radix-2 restoring magnitude divider, one quotient bit per cycle.
// Latency: XLEN cycles; the first bit retires on the start edge itself.
// Backpressure: none; kill abandons the division, start reloads at any time.
module riscv_divider_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dsr_q;
  logic [XLEN-1:0] step_quo, step_rem, step_dsr;
  logic [XLEN-1:0] quo_nxt, rem_nxt;
  logic [XLEN:0]   rem_shift;
  logic            ge;

  // On the start edge the step works straight off the inputs.
  assign step_quo  = start ? dividend : quo_q;
  assign step_rem  = start ? '0       : rem_q;
  assign step_dsr  = start ? divisor  : dsr_q;

  assign rem_shift = {step_rem, step_quo[XLEN-1]};
  assign ge        = rem_shift >= {1'b0, step_dsr};
  assign rem_nxt   = ge ? XLEN'(rem_shift - {1'b0, step_dsr}) : rem_shift[XLEN-1:0];
  assign quo_nxt   = {step_quo[XLEN-2:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (kill) begin
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      dsr_q <= divisor;
      cnt_q <= CW'(XLEN - 1);
    end else if (cnt_q != '0) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // High in the cycle whose closing edge retires the final quotient bit.
  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/riscv_muldiv_unit.sv
// RV32M execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one op in flight.
// Latency: MUL* MUL_LATENCY cycles, DIV/REM XLEN+1, div special cases and illegal ops 1.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, flush kills.
module riscv_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            out_illegal,
  output logic            busy
);

  localparam int              PW       = 2 * XLEN + 2;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [1:0]      MUL_LAST = (MUL_LATENCY > 1) ? 2'(MUL_LATENCY - 2) : 2'd0;

  md_state_t       state_q, state_d;
  logic [2:0]      funct3, funct3_q;
  logic            op_legal, is_div, div_signed, div_rem, div_zero, div_ovf;
  logic            accept, div_start, div_done;
  logic            a_sgn, b_sgn;
  logic [PW-1:0]   a_wide, b_wide, mul_prod, mul_out;
  logic [XLEN-1:0] mul_now, mul_fin;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN-1:0] div_quo, div_rmd, quo_fix, rem_fix;
  logic            q_neg_q, r_neg_q;
  logic [1:0]      mul_cnt_q;
  logic            load_result, illegal_d, illegal_q;
  logic [XLEN-1:0] result_d, result_q;
  logic            unused_bits;

  // Decode
  assign funct3     = instruction[14:12];
  assign op_legal   = (instruction[6:0] == OPC_ARI_RTYPE) && (instruction[31:25] == FNC7_MULDIV);
  assign is_div     = funct3 inside {FNC_DIV, FNC_DIVU, FNC_REM, FNC_REMU};
  assign div_signed = (funct3 == FNC_DIV) || (funct3 == FNC_REM);
  assign div_rem    = (funct3 == FNC_REM) || (funct3 == FNC_REMU);
  assign div_zero   = (rs2 == '0);
  assign div_ovf    = div_signed && (rs1 == INT_MIN) && (rs2 == '1);
  assign special_res = div_zero ? (div_rem ? rs1 : '1) : (div_rem ? '0 : rs1);

  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign div_start = accept && op_legal && is_div && !div_zero && !div_ovf;

  // Operands extended to full product width so one unsigned multiply covers every signedness.
  assign a_sgn    = (funct3 != FNC_MULHU) && rs1[XLEN-1];
  assign b_sgn    = ((funct3 == FNC_MUL) || (funct3 == FNC_MULH)) && rs2[XLEN-1];
  assign a_wide   = {{(XLEN+2){a_sgn}}, rs1};
  assign b_wide   = {{(XLEN+2){b_sgn}}, rs2};
  assign mul_prod = a_wide * b_wide;

  generate
    if (MUL_LATENCY == 1) begin : g_mul_comb
      assign mul_out = mul_prod;
    end else begin : g_mul_pipe
      logic [PW-1:0] pipe [MUL_LATENCY-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_LATENCY - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= mul_prod;
          for (int i = 1; i < MUL_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign mul_out = pipe[MUL_LATENCY-2];
    end
  endgenerate

  assign mul_now = (funct3 == FNC_MUL)   ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  assign mul_fin = (funct3_q == FNC_MUL) ? mul_out[XLEN-1:0]  : mul_out[2*XLEN-1:XLEN];

  assign a_mag = (div_signed && rs1[XLEN-1]) ? -rs1 : rs1;
  assign b_mag = (div_signed && rs2[XLEN-1]) ? -rs2 : rs2;

  riscv_divider_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .kill      (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rmd)
  );

  assign quo_fix = q_neg_q ? -div_quo : div_quo;
  assign rem_fix = r_neg_q ? -div_rmd : div_rmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      funct3_q  <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      mul_cnt_q <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q  <= funct3;
        q_neg_q   <= div_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
        r_neg_q   <= div_signed && rs1[XLEN-1];
        mul_cnt_q <= '0;
      end else if (state_q == ST_MUL) begin
        mul_cnt_q <= mul_cnt_q + 2'd1;
      end
      if (load_result) begin
        result_q  <= result_d;
        illegal_q <= illegal_d;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    load_result = 1'b0;
    illegal_d   = 1'b0;
    result_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!op_legal) begin
            state_d     = ST_DONE;
            load_result = 1'b1;
            illegal_d   = 1'b1;
          end else if (!is_div) begin
            if (MUL_LATENCY == 1) begin
              state_d     = ST_DONE;
              load_result = 1'b1;
              result_d    = mul_now;
            end else begin
              state_d = ST_MUL;
            end
          end else if (div_zero || div_ovf) begin
            state_d     = ST_DONE;
            load_result = 1'b1;
            result_d    = special_res;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        if (mul_cnt_q == MUL_LAST) begin
          state_d     = ST_DONE;
          load_result = 1'b1;
          result_d    = mul_fin;
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d     = ST_DONE;
        load_result = 1'b1;
        result_d    = ((funct3_q == FNC_REM) || (funct3_q == FNC_REMU)) ? rem_fix : quo_fix;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush wins over accept, completion and out_ready alike.
    if (flush) begin
      state_d     = ST_IDLE;
      load_result = 1'b0;
    end
  end

  assign out_valid   = (state_q == ST_DONE);
  assign out_illegal = out_valid && illegal_q;
  assign busy        = (state_q != ST_IDLE);
  assign result      = result_q;

  assign unused_bits = ^{instruction[24:15], instruction[11:7],
                         mul_prod[PW-1:2*XLEN], mul_out[PW-1:2*XLEN]};

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed bench for riscv_muldiv_unit (XLEN=32, MUL_LATENCY=2) with hand-computed results.
module tb_riscv_muldiv_unit;
  import riscv_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        out_illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;

  riscv_muldiv_unit #(.XLEN(32), .MUL_LATENCY(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .rs1         (rs1),
    .rs2         (rs2),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, OPC_ARI_RTYPE};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered and left #1 after a rising edge; the accept edge is consumed here.
  task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue.in_ready", 64'(in_ready), 64'(1));
    instruction = instr;
    rs1 = a;
    rs2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input logic exp_ill, input int hold);
    int lat = 1;
    issue(instr, a, b);
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".valid"},   64'(out_valid),   64'(1));
    check({tag, ".latency"}, 64'(lat),         64'(exp_lat));
    check({tag, ".result"},  64'(result),      64'(exp_res));
    check({tag, ".illegal"}, 64'(out_illegal), 64'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_result"},   64'(result),    64'(exp_res));
      check({tag, ".hold_in_ready"}, 64'(in_ready),  64'(0));
      check({tag, ".hold_valid"},    64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, 64'(out_valid), 64'(0));
    check({tag, ".idle_ready"}, 64'(in_ready),  64'(1));
  endtask

  initial begin
    int seen_valid;

    // Reset state
    #12;
    check("rst.in_ready",    64'(in_ready),    64'(1));
    check("rst.out_valid",   64'(out_valid),   64'(0));
    check("rst.busy",        64'(busy),        64'(0));
    check("rst.result",      64'(result),      64'(0));
    check("rst.out_illegal", 64'(out_illegal), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiplies
    run_op("mul_7x-3",  mk(FNC7_MULDIV, FNC_MUL),    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2, 1'b0, 0);
    run_op("mulhu_max", mk(FNC7_MULDIV, FNC_MULHU),  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1'b0, 0);
    run_op("mulh_m1",   mk(FNC7_MULDIV, FNC_MULH),   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2, 1'b0, 0);
    run_op("mulhsu",    mk(FNC7_MULDIV, FNC_MULHSU), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b0, 0);

    // Iterative divides
    run_op("div_-20_3", mk(FNC7_MULDIV, FNC_DIV),  32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33, 1'b0, 0);
    run_op("rem_-20_3", mk(FNC7_MULDIV, FNC_REM),  32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33, 1'b0, 0);
    run_op("divu_100_7", mk(FNC7_MULDIV, FNC_DIVU), 32'd100,     32'd7,        32'd14,       33, 1'b0, 0);
    run_op("remu_100_7", mk(FNC7_MULDIV, FNC_REMU), 32'd100,     32'd7,        32'd2,        33, 1'b0, 0);
    run_op("rem_20_-3", mk(FNC7_MULDIV, FNC_REM),  32'd20,       32'hFFFFFFFD, 32'd2,        33, 1'b0, 0);

    // Special cases resolved at accept
    run_op("div_by0",  mk(FNC7_MULDIV, FNC_DIV),  32'd9,        32'd0,        32'hFFFFFFFF, 1, 1'b0, 0);
    run_op("remu_by0", mk(FNC7_MULDIV, FNC_REMU), 32'd5,        32'd0,        32'd5,        1, 1'b0, 0);
    run_op("div_ovf",  mk(FNC7_MULDIV, FNC_DIV),  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0, 0);
    run_op("rem_ovf",  mk(FNC7_MULDIV, FNC_REM),  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0, 0);

    // Result held under backpressure
    run_op("hold_mul", mk(FNC7_MULDIV, FNC_MUL), 32'd5, 32'd6, 32'd30, 2, 1'b0, 10);

    // Flush mid-division, with out_ready high to check it cannot leak a result
    issue(mk(FNC7_MULDIV, FNC_DIV), 32'd1000, 32'd7);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("flush.pre_busy", 64'(busy), 64'(1));
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b0;
    check("flush.busy",      64'(busy),      64'(0));
    check("flush.out_valid", 64'(out_valid), 64'(0));
    check("flush.in_ready",  64'(in_ready),  64'(1));
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    check("flush.no_result", 64'(seen_valid), 64'(0));
    run_op("mul_3x4", mk(FNC7_MULDIV, FNC_MUL), 32'd3, 32'd4, 32'd12, 2, 1'b0, 0);

    // Non-M instruction
    run_op("add_illegal", mk(7'b0000000, 3'b000), 32'd11, 32'd22, 32'd0, 1, 1'b1, 0);
    run_op("after_illegal", mk(FNC7_MULDIV, FNC_MUL), 32'd2, 32'd9, 32'd18, 2, 1'b0, 0);

    // Asynchronous reset during a division
    issue(mk(FNC7_MULDIV, FNC_DIV), 32'd100, 32'd3);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.in_ready",  64'(in_ready),  64'(1));
    check("arst.out_valid", 64'(out_valid), 64'(0));
    check("arst.busy",      64'(busy),      64'(0));
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst.ready_after", 64'(in_ready), 64'(1));
    run_op("post_rst_divu", mk(FNC7_MULDIV, FNC_DIVU), 32'd100, 32'd7, 32'd14, 33, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
